// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the Mini-CPU 8-bit ALU: IDLE/DECODE/READ/EXEC/WRITE, owns W and STATUS C/DC/Z.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to add the sticky illegal_op output for unlisted opcodes.
module alu_sequencer #(
  parameter int          RF_AW   = 7,
  parameter logic [7:0]  W_RESET = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [13:0]      instr,
  output logic [RF_AW-1:0] reg_raddr,
  input  logic [7:0]       reg_rdata,
  output logic [RF_AW-1:0] reg_waddr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             alu_clr,
  output logic             alu_swap_n_mov,
  output logic             alu_rlf_n_rrf,
  output logic             alu_sub,
  output logic             alu_c_in,
  output logic [1:0]       alu_op_mux_l,
  output logic [1:0]       alu_op_mux_a,
  output logic [1:0]       alu_out_mux,
  output logic [7:0]       alu_op_a,
  output logic [7:0]       alu_op_b,
  input  logic [7:0]       alu_out,
  input  logic             alu_c_new,
  input  logic             alu_dc_new,
  input  logic             alu_z_new,
  output logic [7:0]       w_reg,
  output logic             status_c,
  output logic             status_dc,
  output logic             status_z,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  output logic             illegal_op,
`endif
  output logic             done
);

  typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WRITE} state_t;
  typedef enum logic [1:0] {K_NOP, K_ALU, K_MOVWF, K_MOVLW} kind_t;

  state_t      state, state_next;
  logic [13:0] instr_q;
  logic [7:0]  opf_q;
  logic [7:0]  res_q;
  logic        c_q, dc_q, z_q;

  kind_t       kind;
  logic        dec_clr, dec_swap, dec_rlf, dec_sub;
  logic [1:0]  dec_mux_l, dec_mux_a, dec_out_mux;
  logic        aff_c, aff_dc, aff_z;
  logic        dest_f;

  assign dest_f = instr_q[7];

  // Adder sub-select: 0 = add/sub, 1 = increment, 2 = decrement.
  always_comb begin
    kind        = K_NOP;
    dec_clr     = 1'b0;
    dec_swap    = 1'b0;
    dec_rlf     = 1'b0;
    dec_sub     = 1'b0;
    dec_mux_l   = 2'd0;
    dec_mux_a   = 2'd0;
    dec_out_mux = 2'd0;
    aff_c       = 1'b0;
    aff_dc      = 1'b0;
    aff_z       = 1'b0;
    case (instr_q[13:8])
      6'b000111: begin kind = K_ALU; dec_out_mux = 2'd3; dec_mux_a = 2'd0;
                       aff_c = 1'b1; aff_dc = 1'b1; aff_z = 1'b1; end
      6'b000010: begin kind = K_ALU; dec_out_mux = 2'd3; dec_mux_a = 2'd0; dec_sub = 1'b1;
                       aff_c = 1'b1; aff_dc = 1'b1; aff_z = 1'b1; end
      6'b001010: begin kind = K_ALU; dec_out_mux = 2'd3; dec_mux_a = 2'd1; aff_z = 1'b1; end
      6'b000011: begin kind = K_ALU; dec_out_mux = 2'd3; dec_mux_a = 2'd2; aff_z = 1'b1; end
      6'b000100: begin kind = K_ALU; dec_out_mux = 2'd2; dec_mux_l = 2'd0; aff_z = 1'b1; end
      6'b000101: begin kind = K_ALU; dec_out_mux = 2'd2; dec_mux_l = 2'd1; aff_z = 1'b1; end
      6'b000110: begin kind = K_ALU; dec_out_mux = 2'd2; dec_mux_l = 2'd2; aff_z = 1'b1; end
      6'b001001: begin kind = K_ALU; dec_out_mux = 2'd2; dec_mux_l = 2'd3; aff_z = 1'b1; end
      6'b001101: begin kind = K_ALU; dec_out_mux = 2'd1; dec_rlf = 1'b1; aff_c = 1'b1; end
      6'b001100: begin kind = K_ALU; dec_out_mux = 2'd1; dec_rlf = 1'b0; aff_c = 1'b1; end
      6'b001000: begin kind = K_ALU; dec_out_mux = 2'd0; aff_z = 1'b1; end
      6'b001110: begin kind = K_ALU; dec_out_mux = 2'd0; dec_swap = 1'b1; end
      6'b000001: begin kind = K_ALU; dec_out_mux = 2'd0; dec_clr = 1'b1; aff_z = 1'b1; end
      6'b000000: begin if (dest_f) kind = K_MOVWF; end
      default:   begin if (instr_q[13:10] == 4'b1100) kind = K_MOVLW; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = DECODE;
      DECODE:  state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU controls are only live in EXEC so the datapath sees all-zero controls otherwise.
  always_comb begin
    alu_clr        = 1'b0;
    alu_swap_n_mov = 1'b0;
    alu_rlf_n_rrf  = 1'b0;
    alu_sub        = 1'b0;
    alu_c_in       = 1'b0;
    alu_op_mux_l   = 2'd0;
    alu_op_mux_a   = 2'd0;
    alu_out_mux    = 2'd0;
    if (state == EXEC && kind == K_ALU) begin
      alu_clr        = dec_clr;
      alu_swap_n_mov = dec_swap;
      alu_rlf_n_rrf  = dec_rlf;
      alu_sub        = dec_sub;
      alu_c_in       = status_c;
      alu_op_mux_l   = dec_mux_l;
      alu_op_mux_a   = dec_mux_a;
      alu_out_mux    = dec_out_mux;
    end
  end

  assign alu_op_a    = opf_q;
  assign alu_op_b    = w_reg;
  assign instr_ready = (state == IDLE);
  assign done        = (state == WRITE);
  assign reg_raddr   = instr_q[RF_AW-1:0];
  assign reg_waddr   = instr_q[RF_AW-1:0];
  assign reg_wdata   = res_q;
  assign reg_we      = (state == WRITE) && dest_f && (kind == K_ALU || kind == K_MOVWF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= 14'h0000;
      opf_q     <= 8'h00;
      res_q     <= 8'h00;
      c_q       <= 1'b0;
      dc_q      <= 1'b0;
      z_q       <= 1'b0;
      w_reg     <= W_RESET;
      status_c  <= 1'b0;
      status_dc <= 1'b0;
      status_z  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) instr_q <= instr;
        READ: opf_q <= reg_rdata;
        EXEC: begin
          case (kind)
            K_MOVWF: res_q <= w_reg;
            K_MOVLW: res_q <= instr_q[7:0];
            default: res_q <= alu_out;
          endcase
          c_q  <= aff_c  ? alu_c_new  : status_c;
          dc_q <= aff_dc ? alu_dc_new : status_dc;
          z_q  <= aff_z  ? alu_z_new  : status_z;
        end
        WRITE: begin
          if ((kind == K_ALU && !dest_f) || kind == K_MOVLW) w_reg <= res_q;
          if (kind == K_ALU) begin
            status_c  <= c_q;
            status_dc <= dc_q;
            status_z  <= z_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              illegal_op <= 1'b0;
    else if (state == WRITE && kind == K_NOP) illegal_op <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and register file, plus a PIC16-level reference model.
// Honours ALU_SEQ_ILLEGAL_TRAP_EN for the optional illegal_op output.
module tb_alu_sequencer;

  localparam int         RF_AW   = 7;
  localparam logic [7:0] W_RESET = 8'h00;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [13:0]      instr;
  logic [RF_AW-1:0] reg_raddr;
  logic [7:0]       reg_rdata;
  logic [RF_AW-1:0] reg_waddr;
  logic [7:0]       reg_wdata;
  logic             reg_we;
  logic             alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub, alu_c_in;
  logic [1:0]       alu_op_mux_l, alu_op_mux_a, alu_out_mux;
  logic [7:0]       alu_op_a, alu_op_b;
  logic [7:0]       alu_out;
  logic             alu_c_new, alu_dc_new, alu_z_new;
  logic [7:0]       w_reg;
  logic             status_c, status_dc, status_z;
  logic             done;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic             illegal_op;
`endif

  always #5 clk = ~clk;

  alu_sequencer #(.RF_AW(RF_AW), .W_RESET(W_RESET)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .alu_clr(alu_clr), .alu_swap_n_mov(alu_swap_n_mov), .alu_rlf_n_rrf(alu_rlf_n_rrf),
    .alu_sub(alu_sub), .alu_c_in(alu_c_in), .alu_op_mux_l(alu_op_mux_l), .alu_op_mux_a(alu_op_mux_a),
    .alu_out_mux(alu_out_mux), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_out(alu_out),
    .alu_c_new(alu_c_new), .alu_dc_new(alu_dc_new), .alu_z_new(alu_z_new), .w_reg(w_reg),
    .status_c(status_c), .status_dc(status_dc), .status_z(status_z),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .done(done)
  );

  // Register file: synchronous read, data valid the cycle after the address.
  logic [7:0] rf [128];
  logic       init_en;
  logic [6:0] init_addr;
  logic [7:0] init_data;
  always @(posedge clk) begin
    if (init_en)     rf[init_addr] <= init_data;
    else if (reg_we) rf[reg_waddr] <= reg_wdata;
    reg_rdata <= rf[reg_raddr];
  end

  // ALU environment model: mov/swap/clr, shift, logic and adder units.
  logic [8:0] s9;
  logic [4:0] h5;
  always_comb begin
    alu_out    = 8'h00;
    alu_c_new  = 1'b0;
    alu_dc_new = 1'b0;
    s9         = 9'h000;
    h5         = 5'h00;
    case (alu_out_mux)
      2'd0: alu_out = alu_clr ? 8'h00 : (alu_swap_n_mov ? {alu_op_a[3:0], alu_op_a[7:4]} : alu_op_a);
      2'd1: begin
        if (alu_rlf_n_rrf) begin alu_out = {alu_op_a[6:0], alu_c_in}; alu_c_new = alu_op_a[7]; end
        else               begin alu_out = {alu_c_in, alu_op_a[7:1]}; alu_c_new = alu_op_a[0]; end
      end
      2'd2: case (alu_op_mux_l)
        2'd0:    alu_out = alu_op_a | alu_op_b;
        2'd1:    alu_out = alu_op_a & alu_op_b;
        2'd2:    alu_out = alu_op_a ^ alu_op_b;
        default: alu_out = ~alu_op_a;
      endcase
      default: begin
        case (alu_op_mux_a)
          2'd0: begin
            if (alu_sub) begin
              s9 = {1'b0, alu_op_a} + {1'b0, ~alu_op_b} + 9'd1;
              h5 = {1'b0, alu_op_a[3:0]} + {1'b0, ~alu_op_b[3:0]} + 5'd1;
            end else begin
              s9 = {1'b0, alu_op_a} + {1'b0, alu_op_b};
              h5 = {1'b0, alu_op_a[3:0]} + {1'b0, alu_op_b[3:0]};
            end
          end
          2'd1:    begin s9 = {1'b0, alu_op_a} + 9'd1;  h5 = {1'b0, alu_op_a[3:0]} + 5'd1; end
          default: begin s9 = {1'b0, alu_op_a} + 9'h0FF; h5 = {1'b0, alu_op_a[3:0]} + 5'h0F; end
        endcase
        alu_out    = s9[7:0];
        alu_c_new  = s9[8];
        alu_dc_new = h5[4];
      end
    endcase
    alu_z_new = (alu_out == 8'h00);
  end

  int done_seen = 0;
  always @(negedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;

  logic [7:0] m_w;
  logic [7:0] m_rf [128];
  logic       m_c, m_dc, m_z, m_ill;
  logic       exp_we;
  logic [6:0] exp_waddr;
  logic [7:0] exp_wdata;
  logic       obs_we;
  logic [7:0] obs_wdata;
  logic [6:0] obs_waddr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: PIC16 semantics applied to the model's W, flags and file.
  task automatic ref_exec(input logic [13:0] ins);
    logic [5:0] op; logic d; logic [6:0] f; logic [7:0] fv, res; logic [8:0] sum; bit is_alu;
    op = ins[13:8]; d = ins[7]; f = ins[6:0]; fv = m_rf[f]; res = 8'h00; is_alu = 1'b1; sum = 9'h000;
    exp_we = 1'b0; exp_waddr = f; exp_wdata = 8'h00;
    case (op)
      6'h07: begin sum = {1'b0, fv} + {1'b0, m_w}; res = sum[7:0]; m_c = sum[8];
                   m_dc = ({1'b0, fv[3:0]} + {1'b0, m_w[3:0]}) > 5'd15; m_z = (res == 8'h00); end
      6'h02: begin res = fv - m_w; m_c = (fv >= m_w); m_dc = (fv[3:0] >= m_w[3:0]); m_z = (res == 8'h00); end
      6'h0A: begin res = fv + 8'd1; m_z = (res == 8'h00); end
      6'h03: begin res = fv - 8'd1; m_z = (res == 8'h00); end
      6'h04: begin res = fv | m_w;  m_z = (res == 8'h00); end
      6'h05: begin res = fv & m_w;  m_z = (res == 8'h00); end
      6'h06: begin res = fv ^ m_w;  m_z = (res == 8'h00); end
      6'h09: begin res = ~fv;       m_z = (res == 8'h00); end
      6'h0D: begin res = {fv[6:0], m_c}; m_c = fv[7]; end
      6'h0C: begin res = {m_c, fv[7:1]}; m_c = fv[0]; end
      6'h08: begin res = fv; m_z = (res == 8'h00); end
      6'h0E: res = {fv[3:0], fv[7:4]};
      6'h01: begin res = 8'h00; m_z = 1'b1; end
      default: is_alu = 1'b0;
    endcase
    if (is_alu) begin
      if (d) begin exp_we = 1'b1; exp_wdata = res; m_rf[f] = res; end
      else m_w = res;
    end else if (op == 6'h00 && d) begin
      exp_we = 1'b1; exp_wdata = m_w; m_rf[f] = m_w;
    end else if (ins[13:10] == 4'b1100) begin
      m_w = ins[7:0];
    end else begin
      m_ill = 1'b1;
    end
  endtask

  // Issue one instruction from an idle negedge and follow it to the next idle negedge.
  task automatic applyStimulus(input logic [13:0] ins, input bit keep_valid);
    ref_exec(ins);
    exp_done++;
    chk("ready_idle", {15'd0, instr_ready}, 16'd1);
    instr = ins; instr_valid = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (!keep_valid) instr_valid = 1'b0;
      else             instr = 14'($urandom);
      chk("ready_busy", {15'd0, instr_ready}, 16'd0);
      if (cyc < 4) begin
        chk("done_early", {15'd0, done}, 16'd0);
        chk("we_early", {15'd0, reg_we}, 16'd0);
      end else begin
        obs_we = reg_we; obs_wdata = reg_wdata; obs_waddr = reg_waddr;
        chk("done_at_4", {15'd0, done}, 16'd1);
        chk("reg_we", {15'd0, reg_we}, {15'd0, exp_we});
        if (exp_we) begin
          chk("reg_waddr", {9'd0, reg_waddr}, {9'd0, exp_waddr});
          chk("reg_wdata", {8'd0, reg_wdata}, {8'd0, exp_wdata});
        end
      end
    end
    @(posedge clk); @(negedge clk);
    checkOutput();
  endtask

  task automatic checkOutput();
    chk("done_after", {15'd0, done}, 16'd0);
    chk("ready_after", {15'd0, instr_ready}, 16'd1);
    chk("w_reg", {8'd0, w_reg}, {8'd0, m_w});
    chk("flags", {13'd0, status_c, status_dc, status_z}, {13'd0, m_c, m_dc, m_z});
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    chk("illegal_op", {15'd0, illegal_op}, {15'd0, m_ill});
`endif
  endtask

  function automatic logic [5:0] op_of(input int k);
    case (k)
      0: return 6'h07;  1: return 6'h02;  2: return 6'h0A;  3: return 6'h03;
      4: return 6'h04;  5: return 6'h05;  6: return 6'h06;  7: return 6'h09;
      8: return 6'h0D;  9: return 6'h0C; 10: return 6'h08; 11: return 6'h0E;
      default: return 6'h01;
    endcase
  endfunction

  function automatic logic [13:0] rand_instr();
    int sel; logic [6:0] f; logic d; logic [11:0] r;
    sel = int'($urandom_range(0, 17)); f = 7'($urandom); d = 1'($urandom); r = 12'($urandom);
    if (sel < 13)       return {op_of(sel), d, f};
    else if (sel == 13) return {7'b0000001, f};
    else if (sel == 14) return {4'b1100, r[9:0]};
    else if (sel == 15) return {7'b0000000, f};
    else if (sel == 16) return {2'b01, r};
    else                return {6'h3F, d, f};
  endfunction

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 14'h0000;
    init_en = 1'b1; init_addr = 7'd0; init_data = 8'h00;
    m_w = W_RESET; m_c = 1'b0; m_dc = 1'b0; m_z = 1'b0; m_ill = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      init_addr = i[6:0]; init_data = 8'($urandom); m_rf[i] = init_data;
    end
    @(negedge clk);
    init_en = 1'b0;

    chk("rst_w", {8'd0, w_reg}, {8'd0, W_RESET});
    chk("rst_flags", {13'd0, status_c, status_dc, status_z}, 16'd0);
    chk("rst_we_done", {14'd0, reg_we, done}, 16'd0);
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    chk("rst_alu_ctl", {3'd0, alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub, alu_c_in,
                        alu_op_mux_l, alu_op_mux_a, alu_out_mux}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(14'h3001, 0);
    applyStimulus(14'h00A0, 0);
    applyStimulus(14'h300F, 0);
    applyStimulus(14'h07A0, 0);
    chk("add_wdata", {8'd0, obs_wdata}, 16'h0010);
    chk("add_waddr", {9'd0, obs_waddr}, 16'h0020);
    chk("add_flags", {13'd0, status_c, status_dc, status_z}, 16'b010);

    applyStimulus(14'h3005, 0);
    applyStimulus(14'h00A1, 0);
    applyStimulus(14'h0221, 0);
    chk("sub_w", {8'd0, w_reg}, 16'h0000);
    chk("sub_flags", {13'd0, status_c, status_dc, status_z}, 16'b111);
    chk("sub_no_we", {15'd0, obs_we}, 16'd0);

    applyStimulus(14'h3002, 0);
    applyStimulus(14'h00A4, 0);
    applyStimulus(14'h0C24, 0);
    applyStimulus(14'h01A5, 0);
    applyStimulus(14'h3001, 0);
    applyStimulus(14'h00A2, 0);
    chk("rrf_pre_cz", {14'd0, status_c, status_z}, 16'b01);
    applyStimulus(14'h0CA2, 0);
    chk("rrf_wdata", {8'd0, obs_wdata}, 16'h0000);
    chk("rrf_cz", {14'd0, status_c, status_z}, 16'b11);

    applyStimulus(14'h305A, 0);
    chk("movlw_w", {8'd0, w_reg}, 16'h005A);
    applyStimulus(14'h00A3, 0);
    chk("movwf_wdata", {8'd0, obs_wdata}, 16'h005A);
    chk("movwf_waddr", {9'd0, obs_waddr}, 16'h0023);

    applyStimulus(14'h07A0, 1);
    applyStimulus(14'h0A23, 1);
    applyStimulus(14'h09A3, 1);
    instr_valid = 1'b0;
    chk("b2b_done_cnt", 16'(done_seen), 16'(exp_done));

    instr = 14'h07A0; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_we", {15'd0, reg_we}, 16'd0);
    chk("abort_w", {8'd0, w_reg}, {8'd0, W_RESET});
    chk("abort_flags", {13'd0, status_c, status_dc, status_z}, 16'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_hold_we", {14'd0, reg_we, done}, 16'd0);
    end
    rst_n = 1'b1;
    m_w = W_RESET; m_c = 1'b0; m_dc = 1'b0; m_z = 1'b0; m_ill = 1'b0;
    @(negedge clk);
    chk("abort_ready", {15'd0, instr_ready}, 16'd1);
    applyStimulus(14'h0820, 0);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    applyStimulus(14'h3F00, 0);
    chk("trap_set", {15'd0, illegal_op}, 16'd1);
    applyStimulus(14'h3042, 0);
    chk("trap_sticky", {15'd0, illegal_op}, 16'd1);
`endif

    for (int n = 0; n < 60; n++) applyStimulus(rand_instr(), 0);
    chk("done_total", 16'(done_seen), 16'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit ALU datapath (mov/swap/clr, shift, logic and adder units, selected by out_mux) for the Mini-CPU core.
- Accepts one 14-bit PIC16-style instruction per handshake, reads the file operand, and drives the ALU control fields and operands.
- Writes the result back to W or to the register file, and owns the W register and the STATUS flags C, DC, Z.

Parameters:
- RF_AW, 7: register-file address width; the f field is instr[RF_AW-1:0].
- W_RESET, 8'h00: reset value of the W register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  high only in IDLE.
- instr  in  14  instruction word.
- reg_raddr  out  RF_AW  file read address.
- reg_rdata  in  8  file read data, valid the cycle after reg_raddr.
- reg_waddr  out  RF_AW  file write address.
- reg_wdata  out  8  file write data.
- reg_we  out  1  one-cycle write strobe.
- alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub, alu_c_in  out  1 each  ALU controls.
- alu_op_mux_l, alu_op_mux_a, alu_out_mux  out  2 each  ALU selects.
- alu_op_a, alu_op_b  out  8 each  drive both operand pairs (A1/A, B1/B).
- alu_out  in  8  ALU result.
- alu_c_new, alu_dc_new, alu_z_new  in  1 each  ALU flags.
- w_reg  out  8  W register.
- status_c, status_dc, status_z  out  1 each  flags.
- done  out  1  one-cycle pulse at retirement.

Behaviour:
- Reset: state IDLE; w_reg=W_RESET; all flags 0; reg_we=0; done=0; all ALU control outputs 0.
- Handshake: an instruction is accepted when instr_valid & instr_ready. instr is latched on acceptance. instr_valid while busy is ignored.
- FSM:
  - IDLE -> DECODE on accept.
  - DECODE: reg_raddr = f.
  - READ: latch reg_rdata as opF.
  - EXEC: drive ALU controls; alu_op_a=opF, alu_op_b=W; alu_c_in=status_c. At the end of EXEC, register alu_out and the flags.
  - WRITE: commit the result, pulse done -> IDLE.
  - Latency: done comes 4 cycles after acceptance; next accept is possible in the following cycle.
- Destination: d=instr[7]. d=0 writes W; d=1 asserts reg_we with reg_waddr=f and reg_wdata=result.
- Decode (instr[13:8], then out_mux/selection, then flags affected):
  - 000111 ADDWF: 11, add; C DC Z.
  - 000010 SUBWF: 11, sub=1, f-W; C DC Z.
  - 001010 INCF: 11, inc; Z.
  - 000011 DECF: 11, dec; Z.
  - 000100 IORWF: 10, l=0; Z.
  - 000101 ANDWF: 10, l=1; Z.
  - 000110 XORWF: 10, l=2; Z.
  - 001001 COMF: 10, l=3; Z.
  - 001101 RLF: 01, rlf=1; C.
  - 001100 RRF: 01, rlf=0; C.
  - 001000 MOVF: 00, mov; Z.
  - 001110 SWAPF: 00, swap; none.
  - 000001 CLRF/CLRW: 00, clr=1; Z.
  - 000000 with d=1 MOVWF: f<-W; no flags, no ALU use.
  - 11_00xx MOVLW: W<-instr[7:0]; no flags, no reg_we.
- Unlisted opcodes (including 000000 with d=0): NOP. done still pulses; no writes, no flag change.
- Flags not affected by an instruction hold their value. C/DC are taken verbatim from the ALU (C on SUB is not-borrow).
- Reset asserted mid-operation: abort, no write, return to IDLE.

Optional Feature:
- ALU_SEQ_ILLEGAL_TRAP_EN: adds output illegal_op (1 bit, sticky). It sets in WRITE of an unlisted opcode and clears only on reset; the instruction still retires as a NOP.
- Without the macro: no port; unlisted opcodes are a silent NOP.

Test Plan:
- W=0x0F, f[0x20]=0x01, instr 0x07A0 (ADDWF 0x20,1) -> at WRITE reg_we=1, waddr=0x20, wdata=0x10; C=0, DC=1, Z=0; done exactly 4 cycles after accept.
- W=0x05, f[0x21]=0x05, instr 0x0221 (SUBWF 0x21,0) -> W=0x00, Z=1, C=1, DC=1, reg_we stays 0.
- C=0, Z=1, f[0x22]=0x01, instr 0x0CA2 (RRF 0x22,1) -> wdata=0x00, C=1, Z remains 1.
- instr 0x305A (MOVLW) then 0x00A3 (MOVWF 0x23) -> W=0x5A; then reg_we with waddr=0x23, wdata=0x5A; flags unchanged.
- instr_valid held high for 3 back-to-back instructions -> instr_ready low DECODE..WRITE; exactly 3 done pulses, no instruction lost or duplicated.
- rst_n low during EXEC of an ADDWF -> no reg_we; w_reg=W_RESET; flags 0; instr_ready=1 after release. With the trap macro, instr 0x3F00-class unlisted opcode -> illegal_op=1 sticky.
